tictactoe_ctrl: RTL and testbench
=================================

TICTACTOE_CTRL -- requirements
Module: tictactoe_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 The ports SHALL be as follows (name  direction  width  meaning):
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- play  in  1  move request level (debounced key), acted on at rising edge only
- sel  in  4  target cell index, valid 1..9, sampled in the request cycle
- clr  in  1  new-game request, synchronous, level-sensitive
- pos1..pos9  out  2 each  cell state: 00 empty, 01 player1, 10 player2, 11 never driven
- who  out  2  PLAY: player to move (01/10); WIN: winner (01/10); DRAW: 00
- ill  out  1  last request was illegal, sticky
- game_over  out  1  high in WIN or DRAW

Function
REQ-003 Request detection SHALL register play into play_q every cycle; req = play AND NOT play_q; holding play high SHALL produce exactly one req.
REQ-004 The state machine SHALL have states PLAY, WIN and DRAW; the reset state SHALL be PLAY with player1 to move.
REQ-005 In PLAY, req with sel in 1..9 and the selected cell at 00 SHALL be legal:
- cell written with the current player code on the same edge
- ill cleared
- turn toggled
REQ-006 In PLAY, req with sel = 0, sel > 9, or the selected cell non-zero SHALL be illegal:
- board and turn unchanged
- ill set to 1 on that edge, held until the next legal move, clr or rst
REQ-007 Win/draw evaluation SHALL use the post-move board (combinational next-board) so the state changes on the same edge as the cell write; there SHALL be no cycle where a won board is in PLAY.
REQ-008 A win SHALL be three equal non-zero cells on any of the 8 lines: rows 123, 456, 789; columns 147, 258, 369; diagonals 159, 357.
REQ-009 A legal move producing a win SHALL go to WIN with who = mover's code; otherwise a move filling the ninth cell SHALL go to DRAW with who = 00; win SHALL take priority over draw when both occur on the ninth move.
REQ-010 In WIN and DRAW, req SHALL be ignored: board, who and ill unchanged, ill not set.
REQ-011 clr SHALL, on the next edge, clear all cells to 00, clear ill, set PLAY, and set who = 01; clr SHALL take priority over a coincident req.
REQ-012 All outputs SHALL be registered; each output change SHALL appear one clock after the causing edge-sampled input.
REQ-013 who in PLAY SHALL alternate 01, 10, 01... starting at 01 after every rst or clr, regardless of which player ended the previous game.

Reset
REQ-014 rst SHALL take priority over clr and play.
REQ-015 On rst the block SHALL force:
- pos1..pos9 = 00, who = 01, ill = 0, game_over = 0
- state = PLAY, play_q = 1 so a key already held at reset release does not generate a req
REQ-016 rst asserted mid-game or in WIN/DRAW SHALL discard the whole game state on that edge.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Legal sequence: after rst, play pulses with sel = 1, 4, 2, 5, 3 -> pos1 = pos2 = pos3 = 01, pos4 = pos5 = 10, state WIN, who = 01, game_over = 1 on the edge of the fifth move.
- Occupied and out-of-range cells: after sel = 5 is played by P1, P2 plays sel = 5 -> ill = 1, who stays 10, board unchanged; P2 then plays sel = 12 -> ill stays 1; P2 then plays sel = 6 -> ill = 0, pos6 = 10, who = 01.
- Held key: play high for 20 cycles with sel = 7 -> exactly one write (pos7 = 01); who toggles once only.
- Draw: move order 1, 2, 3, 5, 4, 6, 8, 7, 9 -> all cells non-zero, no line, state DRAW, who = 00, game_over = 1; a further req with sel = 1 changes nothing.
- Ninth move wins: move order 1, 2, 3, 5, 4, 6, 8, 9, 7 -> P1 completes 147 on the ninth move -> state WIN, who = 01, not DRAW.
- Priority: clr and a rising play on the same cycle mid-game -> board all 00, who = 01, ill = 0, no write; rst with clr high -> reset values, and a play held through reset release creates no move.

Source files
------------

// File: rtl/tictactoe_ctrl.sv
// ---------------------------------------------------------------------------
// tictactoe_ctrl
//
// Two-player tic-tac-toe referee. Holds the 3x3 board, decides whose turn it
// is, rejects illegal moves and detects win/draw on the same edge as the
// move that causes it.
//
// Ports
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous active-high reset (highest priority)
//   play       move key level; a move is requested on its rising edge only
//   sel[3:0]   target cell 1..9 (row-major), sampled in the request cycle
//   clr        synchronous new-game request (priority over a move request)
//   pos1..pos9 cell contents: 00 empty, 01 player1, 10 player2
//   who        PLAY: player to move; WIN: winner; DRAW: 00
//   ill        last request was illegal (sticky until legal move/clr/rst)
//   game_over  high in WIN or DRAW
// ---------------------------------------------------------------------------
module tictactoe_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       play,
    input  logic [3:0] sel,
    input  logic       clr,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic [1:0] pos9,
    output logic [1:0] who,
    output logic       ill,
    output logic       game_over
);

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_WIN  = 2'd1,
        ST_DRAW = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] cell_reg  [9];
    logic [1:0] cell_next [9];
    logic [1:0] who_reg, who_next;
    logic       ill_reg, ill_next;
    logic       over_reg, over_next;
    logic       play_q_reg;

    // Per-cell decode of the request and the candidate post-move board.
    logic [8:0] hit;      // sel addresses this cell (only true for 1..9)
    logic [8:0] empty;    // cell currently empty
    logic [8:0] filled;   // cell non-empty on the post-move board
    logic [1:0] moved [9];

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_cell
            assign hit[gi]    = (sel == 4'(gi + 1));
            assign empty[gi]  = (cell_reg[gi] == 2'b00);
            assign moved[gi]  = hit[gi] ? who_reg : cell_reg[gi];
            assign filled[gi] = (moved[gi] != 2'b00);
        end
    endgenerate

    function automatic logic line3(input logic [1:0] a, input logic [1:0] b,
                                   input logic [1:0] c);
        return (a != 2'b00) && (a == b) && (b == c);
    endfunction

    logic req;
    logic legal;
    logic win_after;
    logic full_after;

    assign req   = play & ~play_q_reg;
    // hit is one-hot for sel 1..9 and all-zero otherwise, so an
    // out-of-range index can never look like an empty cell.
    assign legal = |(hit & empty);

    // Evaluated on the post-move board so WIN/DRAW lands on the move edge.
    assign win_after = line3(moved[0], moved[1], moved[2])
                     | line3(moved[3], moved[4], moved[5])
                     | line3(moved[6], moved[7], moved[8])
                     | line3(moved[0], moved[3], moved[6])
                     | line3(moved[1], moved[4], moved[7])
                     | line3(moved[2], moved[5], moved[8])
                     | line3(moved[0], moved[4], moved[8])
                     | line3(moved[2], moved[4], moved[6]);
    assign full_after = &filled;

    always_comb begin
        state_next = state_reg;
        who_next   = who_reg;
        ill_next   = ill_reg;
        over_next  = over_reg;
        for (int i = 0; i < 9; i++) begin
            cell_next[i] = cell_reg[i];
        end

        if (clr) begin
            state_next = ST_PLAY;
            who_next   = 2'b01;
            ill_next   = 1'b0;
            over_next  = 1'b0;
            for (int i = 0; i < 9; i++) begin
                cell_next[i] = 2'b00;
            end
        end else if (req && (state_reg == ST_PLAY)) begin
            if (legal) begin
                ill_next = 1'b0;
                for (int i = 0; i < 9; i++) begin
                    cell_next[i] = moved[i];
                end
                if (win_after) begin
                    // who keeps the mover's code, which names the winner
                    state_next = ST_WIN;
                    over_next  = 1'b1;
                end else if (full_after) begin
                    state_next = ST_DRAW;
                    who_next   = 2'b00;
                    over_next  = 1'b1;
                end else begin
                    who_next = who_reg ^ 2'b11;
                end
            end else begin
                ill_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_PLAY;
            who_reg    <= 2'b01;
            ill_reg    <= 1'b0;
            over_reg   <= 1'b0;
            // Pretend the key was already down so a key held across reset
            // release does not look like a fresh press.
            play_q_reg <= 1'b1;
            for (int i = 0; i < 9; i++) begin
                cell_reg[i] <= 2'b00;
            end
        end else begin
            state_reg  <= state_next;
            who_reg    <= who_next;
            ill_reg    <= ill_next;
            over_reg   <= over_next;
            play_q_reg <= play;
            for (int i = 0; i < 9; i++) begin
                cell_reg[i] <= cell_next[i];
            end
        end
    end

    assign pos1      = cell_reg[0];
    assign pos2      = cell_reg[1];
    assign pos3      = cell_reg[2];
    assign pos4      = cell_reg[3];
    assign pos5      = cell_reg[4];
    assign pos6      = cell_reg[5];
    assign pos7      = cell_reg[6];
    assign pos8      = cell_reg[7];
    assign pos9      = cell_reg[8];
    assign who       = who_reg;
    assign ill       = ill_reg;
    assign game_over = over_reg;

endmodule

// File: tb/tb_tictactoe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tictactoe_ctrl
//
// Directed bench for tictactoe_ctrl. A table of one-step transactions (move
// pulse, clr pulse or rst pulse) with hand-computed expected board/who/ill/
// game_over, followed by hand-written sequences for held keys and the
// clr/rst priority cases. Boards are written as 9-digit strings, pos1 first,
// digit = cell code (0 empty, 1 player1, 2 player2).
// ---------------------------------------------------------------------------
module tb_tictactoe_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       play = 1'b0;
    logic [3:0] sel = 4'd0;
    logic       clr = 1'b0;
    logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
    logic [1:0] who;
    logic       ill;
    logic       game_over;

    int checks   = 0;
    int failures = 0;

    tictactoe_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .play      (play),
        .sel       (sel),
        .clr       (clr),
        .pos1      (pos1),
        .pos2      (pos2),
        .pos3      (pos3),
        .pos4      (pos4),
        .pos5      (pos5),
        .pos6      (pos6),
        .pos7      (pos7),
        .pos8      (pos8),
        .pos9      (pos9),
        .who       (who),
        .ill       (ill),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    typedef enum int { OP_MOVE, OP_CLR, OP_RST } op_t;

    typedef struct {
        op_t        op;
        logic [3:0] sel;
        string      board;
        logic [1:0] who;
        logic       ill;
        logic       over;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input op_t op, input logic [3:0] s,
                                input string b, input logic [1:0] w,
                                input logic il, input logic ov);
        vec_t v;
        v.op    = op;
        v.sel   = s;
        v.board = b;
        v.who   = w;
        v.ill   = il;
        v.over  = ov;
        vecs.push_back(v);
    endfunction

    function automatic logic [17:0] str2board(input string s);
        logic [17:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) begin
            r[2*i +: 2] = 2'(s[i] - 8'd48);
        end
        return r;
    endfunction

    function automatic string board2str(input logic [17:0] b);
        string s;
        s = "";
        for (int i = 0; i < 9; i++) begin
            s = {s, $sformatf("%0d", b[2*i +: 2])};
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string name, input string exp_board,
                               input logic [1:0] exp_who, input logic exp_ill,
                               input logic exp_over);
        logic [17:0] act;
        act = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
        checks++;
        if (act !== str2board(exp_board)) begin
            failures++;
            $display("FAIL %s board: got %s want %s", name, board2str(act), exp_board);
        end
        checks++;
        if (who !== exp_who) begin
            failures++;
            $display("FAIL %s who: got %b want %b", name, who, exp_who);
        end
        checks++;
        if (ill !== exp_ill) begin
            failures++;
            $display("FAIL %s ill: got %b want %b", name, ill, exp_ill);
        end
        checks++;
        if (game_over !== exp_over) begin
            failures++;
            $display("FAIL %s game_over: got %b want %b", name, game_over, exp_over);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- transaction table ----
        add(OP_RST,  4'd0,  "000000000", 2'b01, 1'b0, 1'b0);
        // legal sequence ending in a row-1 win for player1
        add(OP_MOVE, 4'd1,  "100000000", 2'b10, 1'b0, 1'b0);
        add(OP_MOVE, 4'd4,  "100200000", 2'b01, 1'b0, 1'b0);
        add(OP_MOVE, 4'd2,  "110200000", 2'b10, 1'b0, 1'b0);
        add(OP_MOVE, 4'd5,  "110220000", 2'b01, 1'b0, 1'b0);
        add(OP_MOVE, 4'd3,  "111220000", 2'b01, 1'b0, 1'b1);
        add(OP_MOVE, 4'd6,  "111220000", 2'b01, 1'b0, 1'b1);  // ignored in WIN
        add(OP_MOVE, 4'd0,  "111220000", 2'b01, 1'b0, 1'b1);  // ill not set in WIN
        add(OP_CLR,  4'd0,  "000000000", 2'b01, 1'b0, 1'b0);
        // occupied / out-of-range cells
        add(OP_MOVE, 4'd5,  "000010000", 2'b10, 1'b0, 1'b0);
        add(OP_MOVE, 4'd5,  "000010000", 2'b10, 1'b1, 1'b0);
        add(OP_MOVE, 4'd12, "000010000", 2'b10, 1'b1, 1'b0);
        add(OP_MOVE, 4'd6,  "000012000", 2'b01, 1'b0, 1'b0);
        add(OP_MOVE, 4'd0,  "000012000", 2'b01, 1'b1, 1'b0);
        add(OP_MOVE, 4'd15, "000012000", 2'b01, 1'b1, 1'b0);
        add(OP_MOVE, 4'd1,  "100012000", 2'b10, 1'b0, 1'b0);
        add(OP_CLR,  4'd0,  "000000000", 2'b01, 1'b0, 1'b0);
        // draw
        add(OP_MOVE, 4'd1,  "100000000", 2'b10, 1'b0, 1'b0);
        add(OP_MOVE, 4'd2,  "120000000", 2'b01, 1'b0, 1'b0);
        add(OP_MOVE, 4'd3,  "121000000", 2'b10, 1'b0, 1'b0);
        add(OP_MOVE, 4'd5,  "121020000", 2'b01, 1'b0, 1'b0);
        add(OP_MOVE, 4'd4,  "121120000", 2'b10, 1'b0, 1'b0);
        add(OP_MOVE, 4'd6,  "121122000", 2'b01, 1'b0, 1'b0);
        add(OP_MOVE, 4'd8,  "121122010", 2'b10, 1'b0, 1'b0);
        add(OP_MOVE, 4'd7,  "121122210", 2'b01, 1'b0, 1'b0);
        add(OP_MOVE, 4'd9,  "121122211", 2'b00, 1'b0, 1'b1);
        add(OP_MOVE, 4'd1,  "121122211", 2'b00, 1'b0, 1'b1);  // ignored in DRAW
        add(OP_CLR,  4'd0,  "000000000", 2'b01, 1'b0, 1'b0);
        // ninth move wins on column 147
        add(OP_MOVE, 4'd1,  "100000000", 2'b10, 1'b0, 1'b0);
        add(OP_MOVE, 4'd2,  "120000000", 2'b01, 1'b0, 1'b0);
        add(OP_MOVE, 4'd3,  "121000000", 2'b10, 1'b0, 1'b0);
        add(OP_MOVE, 4'd5,  "121020000", 2'b01, 1'b0, 1'b0);
        add(OP_MOVE, 4'd4,  "121120000", 2'b10, 1'b0, 1'b0);
        add(OP_MOVE, 4'd6,  "121122000", 2'b01, 1'b0, 1'b0);
        add(OP_MOVE, 4'd8,  "121122010", 2'b10, 1'b0, 1'b0);
        add(OP_MOVE, 4'd9,  "121122012", 2'b01, 1'b0, 1'b0);
        add(OP_MOVE, 4'd7,  "121122112", 2'b01, 1'b0, 1'b1);
        // player2 then wins the next game; new game still starts with 01
        add(OP_CLR,  4'd0,  "000000000", 2'b01, 1'b0, 1'b0);
        add(OP_MOVE, 4'd1,  "100000000", 2'b10, 1'b0, 1'b0);
        add(OP_MOVE, 4'd3,  "102000000", 2'b01, 1'b0, 1'b0);
        add(OP_MOVE, 4'd2,  "112000000", 2'b10, 1'b0, 1'b0);
        add(OP_MOVE, 4'd5,  "112020000", 2'b01, 1'b0, 1'b0);
        add(OP_MOVE, 4'd9,  "112020001", 2'b10, 1'b0, 1'b0);
        add(OP_MOVE, 4'd7,  "112020201", 2'b10, 1'b0, 1'b1);  // 357 for player2
        add(OP_CLR,  4'd0,  "000000000", 2'b01, 1'b0, 1'b0);
        // rst mid-game discards board and sticky ill
        add(OP_MOVE, 4'd1,  "100000000", 2'b10, 1'b0, 1'b0);
        add(OP_MOVE, 4'd1,  "100000000", 2'b10, 1'b1, 1'b0);
        add(OP_RST,  4'd0,  "000000000", 2'b01, 1'b0, 1'b0);

        // hold reset for a couple of edges before starting
        tick();
        tick();
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_MOVE: begin play = 1'b1; sel = vecs[i].sel; end
                OP_CLR:  clr = 1'b1;
                default: rst = 1'b1;
            endcase
            tick();
            check_state($sformatf("vec%0d", i), vecs[i].board, vecs[i].who,
                        vecs[i].ill, vecs[i].over);
            $display("vec %0d op=%s sel=%0d board=%s who=%b ill=%b over=%b",
                     i, vecs[i].op.name(), vecs[i].sel, vecs[i].board,
                     who, ill, game_over);
            play = 1'b0;
            clr  = 1'b0;
            rst  = 1'b0;
            tick();
        end

        // ---- held key: exactly one write, one toggle ----
        play = 1'b1;
        sel  = 4'd7;
        for (int k = 0; k < 20; k++) begin
            tick();
            check_state($sformatf("held%0d", k), "000000100", 2'b10, 1'b0, 1'b0);
        end
        $display("held play 20 cycles sel=7 board=%0d%0d%0d%0d%0d%0d%0d%0d%0d who=%b",
                 pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, who);
        play = 1'b0;
        tick();

        // ---- clr coincident with a rising play ----
        play = 1'b1;
        sel  = 4'd7;                        // occupied -> ill
        tick();
        check_state("pre_clr", "000000100", 2'b10, 1'b1, 1'b0);
        play = 1'b0;
        tick();
        clr  = 1'b1;
        play = 1'b1;
        sel  = 4'd9;
        tick();
        check_state("clr_vs_play", "000000000", 2'b01, 1'b0, 1'b0);
        clr = 1'b0;
        tick();                             // play still held: no new request
        check_state("clr_held", "000000000", 2'b01, 1'b0, 1'b0);
        $display("clr with rising play sel=9 board=%0d%0d%0d%0d%0d%0d%0d%0d%0d who=%b ill=%b",
                 pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, who, ill);
        play = 1'b0;
        tick();

        // ---- rst with clr high, play held through reset release ----
        play = 1'b1;
        sel  = 4'd2;
        tick();
        check_state("pre_rst", "010000000", 2'b10, 1'b0, 1'b0);
        play = 1'b0;
        tick();
        rst  = 1'b1;
        clr  = 1'b1;
        play = 1'b1;
        sel  = 4'd1;
        tick();
        check_state("rst_clr", "000000000", 2'b01, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_state($sformatf("rst_held%0d", k), "000000000", 2'b01, 1'b0, 1'b0);
        end
        play = 1'b0;
        tick();
        play = 1'b1;
        tick();
        check_state("post_rst_move", "100000000", 2'b10, 1'b0, 1'b0);
        $display("rst+clr with held play, then fresh move sel=1 board=%0d%0d%0d%0d%0d%0d%0d%0d%0d who=%b",
                 pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, who);
        play = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
